// File: rtl/axi_ram_responder_pkg.sv
// Shared constants and state encoding for the AXI-lite style RAM responder.
package axi_ram_responder_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_R_WAIT = 2'b01,
    S_R      = 2'b10,
    S_W      = 2'b11
  } state_t;

  // Byte address to word address; the caller truncates to the RAM depth.
  function automatic logic [ADDR_W-1:0] word_of(input logic [ADDR_W-1:0] byte_addr);
    return {2'b00, byte_addr[ADDR_W-1:2]};
  endfunction

endpackage

// File: rtl/axi_ram_responder_if.sv
// AR/R/AW/W channel bundle; there is no B channel.
interface axi_ram_responder_if;
  import axi_ram_responder_pkg::*;

  logic [ADDR_W-1:0] ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic              RVALID;
  logic              RREADY;
  logic [ADDR_W-1:0] AWADDR;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic              WVALID;
  logic              WLAST;
  logic              WREADY;

  modport slave (
    input  ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WVALID, WLAST,
    output ARREADY, RDATA, RVALID, AWREADY, WREADY
  );

  modport master (
    output ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WVALID, WLAST,
    input  ARREADY, RDATA, RVALID, AWREADY, WREADY
  );
endinterface

// File: rtl/axi_ram_array.sv
// Single-port synchronous RAM, registered read (old data on a same-cycle write).
module axi_ram_array #(
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] r_mem [2**ADDR_W];

  always_ff @(posedge CLK) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    rdata <= r_mem[addr];
  end

endmodule

// File: rtl/axi_ram_responder.sv
// Single-outstanding RAM responder: AR/R reads with fixed latency, AW/W single-beat writes.
module axi_ram_responder
  import axi_ram_responder_pkg::*;
#(
  parameter int ADDR_WORDS_LOG2 = 10,
  parameter int READ_LATENCY    = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  axi_ram_responder_if.slave   bus
);

  localparam int AW = ADDR_WORDS_LOG2;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LATENCY - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [AW-1:0]     r_index;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;

  logic [AW-1:0]     w_ar_index;
  logic [AW-1:0]     w_aw_index;
  logic [AW-1:0]     w_ram_addr;
  logic              w_ram_we;
  logic [DATA_W-1:0] w_ram_rdata;
  logic              w_arready;
  logic              w_awready;
  logic              w_wready;
  logic              w_unused;

  assign w_ar_index = AW'(word_of(bus.ARADDR));
  assign w_aw_index = AW'(word_of(bus.AWADDR));
  assign w_unused   = &{1'b0, bus.WLAST};

  always_comb begin
    w_next_state = r_state;
    w_arready    = 1'b0;
    w_awready    = 1'b0;
    w_wready     = 1'b0;
    w_ram_we     = 1'b0;
    w_ram_addr   = r_index;
    case (r_state)
      S_IDLE: begin
        w_awready  = 1'b1;
        w_arready  = !bus.AWVALID;
        // Present the AR index straight away so the RAM output is ready
        // one edge after the handshake, which READ_LATENCY=1 relies on.
        w_ram_addr = w_ar_index;
        if (bus.AWVALID) begin
          w_next_state = S_W;
        end else if (bus.ARVALID) begin
          w_next_state = S_R_WAIT;
        end
      end
      S_R_WAIT: begin
        if (r_cnt == '0) begin
          w_next_state = S_R;
        end
      end
      S_R: begin
        if (bus.RREADY) begin
          w_next_state = S_IDLE;
        end
      end
      S_W: begin
        w_wready = 1'b1;
        if (bus.WVALID) begin
          w_ram_we     = 1'b1;
          w_next_state = S_IDLE;
        end
      end
    endcase
    if (RST) begin
      w_arready = 1'b0;
      w_awready = 1'b0;
      w_wready  = 1'b0;
      w_ram_we  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_index  <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (bus.AWVALID) begin
            r_index <= w_aw_index;
          end else if (bus.ARVALID) begin
            r_index <= w_ar_index;
            r_cnt   <= LAT_LOAD;
          end
        end
        S_R_WAIT: begin
          if (r_cnt == '0) begin
            r_rdata  <= w_ram_rdata;
            r_rvalid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_R: begin
          if (bus.RREADY) begin
            r_rvalid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ARREADY = w_arready;
  assign bus.AWREADY = w_awready;
  assign bus.WREADY  = w_wready;
  assign bus.RVALID  = r_rvalid && !RST;
  assign bus.RDATA   = r_rdata;

  axi_ram_array #(
    .ADDR_W (AW)
  ) u_array (
    .CLK   (CLK),
    .addr  (w_ram_addr),
    .we    (w_ram_we),
    .wdata (bus.WDATA),
    .rdata (w_ram_rdata)
  );

endmodule

// File: tb/tb_axi_ram_responder.sv
// Directed stimulus with a scoreboard queue; a negedge monitor checks every R beat.
module tb_axi_ram_responder;

  localparam int LAT = 2;

  typedef struct {
    logic [31:0] data;
    int          ar_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_ram_responder_if bus();

  axi_ram_responder #(
    .ADDR_WORDS_LOG2 (10),
    .READ_LATENCY    (LAT)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_xfer = 0;
  int   n_reads = 0;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no handshake within budget, expected one", name);
  endtask

  // Monitor: latency of each new beat, stability under stall, data on handshake.
  initial begin
    logic        prev_rv = 1'b0;
    logic        prev_hs = 1'b0;
    logic [31:0] prev_data = '0;
    logic        rv;
    exp_t        e;
    forever begin
      @(negedge clk);
      rv = bus.RVALID;
      if (prev_hs) begin
        check("rvalid_drop", {31'd0, rv}, 32'd0);
      end else if (prev_rv) begin
        check("rvalid_hold", {31'd0, rv}, 32'd1);
        check("rdata_hold", bus.RDATA, prev_data);
      end
      if (rv && (!prev_rv || prev_hs)) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rvalid: got RVALID=1 rdata=%h, expected RVALID=0", bus.RDATA);
        end else begin
          check("r_latency", 32'(cyc - exp_q[0].ar_cyc), 32'(LAT));
        end
      end
      if (rv && bus.RREADY && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rdata", bus.RDATA, e.data);
        n_xfer++;
      end
      prev_hs   = rv && bus.RREADY;
      prev_rv   = rv;
      prev_data = bus.RDATA;
    end
  end

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic last);
    bit ok;
    bus.AWADDR  = addr;
    bus.AWVALID = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.AWREADY === 1'b1) begin ok = 1; break; end
    end
    if (!ok) timeout("aw_handshake");
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
    bus.WDATA   = data;
    bus.WVALID  = 1'b1;
    bus.WLAST   = last;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.WREADY === 1'b1) begin ok = 1; break; end
    end
    if (!ok) timeout("w_handshake");
    @(posedge clk); #1;
    bus.WVALID = 1'b0;
    bus.WLAST  = 1'b0;
    $display("write addr=%h data=%h wlast=%0b", addr, data, last);
  endtask

  task automatic wait_drained();
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.RVALID !== 1'b1) begin ok = 1; break; end
    end
    if (!ok) begin
      timeout("r_drain");
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic issue_ar(input logic [31:0] addr, input logic [31:0] exp_data);
    bit ok;
    bus.ARADDR  = addr;
    bus.ARVALID = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ARREADY === 1'b1) begin
        exp_q.push_back('{data: exp_data, ar_cyc: cyc + 1});
        n_reads++;
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("ar_handshake");
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data, input int stall);
    bit ok;
    bus.RREADY = (stall == 0);
    issue_ar(addr, exp_data);
    if (stall > 0) begin
      ok = 0;
      for (int i = 0; i < 20; i++) begin
        if (bus.RVALID === 1'b1) begin ok = 1; break; end
        @(negedge clk);
      end
      if (!ok) timeout("rvalid_rise");
      repeat (stall - 1) @(negedge clk);
      @(posedge clk); #1;
      bus.RREADY = 1'b1;
    end
    wait_drained();
    $display("read  addr=%h expect=%h stall=%0d", addr, exp_data, stall);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b1;
    bus.AWADDR = '0; bus.AWVALID = 1'b0;
    bus.WDATA  = '0; bus.WVALID  = 1'b0; bus.WLAST = 1'b0;
    rst = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arready", {31'd0, bus.ARREADY}, 32'd0);
    check("rst_awready", {31'd0, bus.AWREADY}, 32'd0);
    check("rst_wready",  {31'd0, bus.WREADY},  32'd0);
    check("rst_rvalid",  {31'd0, bus.RVALID},  32'd0);
    check("rst_rdata",   bus.RDATA, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_arready", {31'd0, bus.ARREADY}, 32'd1);
    check("idle_awready", {31'd0, bus.AWREADY}, 32'd1);
    check("idle_wready",  {31'd0, bus.WREADY},  32'd0);
    @(posedge clk); #1;

    do_write(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    do_read (32'h0000_0010, 32'hDEAD_BEEF, 0);

    do_write(32'h0000_0014, 32'hCAFE_F00D, 1'b1);
    do_read (32'h0000_0014, 32'hCAFE_F00D, 5);

    // AW and AR together at 0x20: write must win, read sees the new word
    bus.AWADDR = 32'h20; bus.AWVALID = 1'b1;
    bus.ARADDR = 32'h20; bus.ARVALID = 1'b1;
    @(negedge clk);
    check("both_arready", {31'd0, bus.ARREADY}, 32'd0);
    check("both_awready", {31'd0, bus.AWREADY}, 32'd1);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
    bus.WDATA = 32'h1234_5678; bus.WVALID = 1'b1; bus.WLAST = 1'b1;
    @(negedge clk);
    check("sw_arready", {31'd0, bus.ARREADY}, 32'd0);
    check("sw_wready",  {31'd0, bus.WREADY},  32'd1);
    @(posedge clk); #1;
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    issue_ar(32'h20, 32'h1234_5678);
    wait_drained();
    $display("read  addr=%h expect=%h (after simultaneous AW/AR)", 32'h20, 32'h1234_5678);

    do_write(32'h0000_1004, 32'hA5A5_A5A5, 1'b1);
    do_read (32'h0000_0004, 32'hA5A5_A5A5, 0);

    do_write(32'h0000_0080, 32'h0BAD_F00D, 1'b0);
    do_read (32'h0000_0083, 32'h0BAD_F00D, 0);

    do_write(32'h0000_0010, 32'h0123_4567, 1'b1);
    do_read (32'h0000_0010, 32'h0123_4567, 0);

    // Reset while waiting on read latency
    do_write(32'h0000_0040, 32'h1111_2222, 1'b1);
    bus.ARADDR = 32'h40; bus.ARVALID = 1'b1;
    @(negedge clk);
    check("rw_arready", {31'd0, bus.ARREADY}, 32'd1);
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rw_rst_rvalid",  {31'd0, bus.RVALID},  32'd0);
    check("rw_rst_arready", {31'd0, bus.ARREADY}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rw_post_arready", {31'd0, bus.ARREADY}, 32'd1);
    check("rw_post_awready", {31'd0, bus.AWREADY}, 32'd1);
    check("rw_post_rdata",   bus.RDATA, 32'd0);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    do_read(32'h0000_0040, 32'h1111_2222, 0);

    // Reset while waiting for write data
    bus.AWADDR = 32'h40; bus.AWVALID = 1'b1;
    @(negedge clk);
    check("ww_awready", {31'd0, bus.AWREADY}, 32'd1);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
    bus.WDATA = 32'hBADB_AD00; bus.WVALID = 1'b1; bus.WLAST = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("ww_rst_wready", {31'd0, bus.WREADY}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    @(negedge clk);
    check("ww_post_arready", {31'd0, bus.ARREADY}, 32'd1);
    check("ww_post_awready", {31'd0, bus.AWREADY}, 32'd1);
    check("ww_post_wready",  {31'd0, bus.WREADY},  32'd0);
    @(posedge clk); #1;
    do_read(32'h0000_0040, 32'h1111_2222, 0);

    repeat (3) @(negedge clk);
    check("xfer_count", 32'(n_xfer), 32'(n_reads));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_ram_responder.md
AXI_RAM_RESPONDER -- requirements
Module: axi_ram_responder

Interface
REQ-001 The block SHALL have parameter ADDR_WORDS_LOG2, default 10, giving log2 of the RAM depth in 32-bit words.
REQ-002 The block SHALL have parameter READ_LATENCY, default 2, giving the cycles from the AR handshake edge to the first RVALID high (legal range 1..15).
REQ-003 CLK  input  1  clock; all logic on its rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 ARADDR  input  32  read byte address.
REQ-006 ARVALID  input  1; ARREADY  output  1: read address handshake.
REQ-007 RDATA  output  32; RVALID  output  1; RREADY  input  1: read data handshake.
REQ-008 AWADDR  input  32  write byte address.
REQ-009 AWVALID  input  1; AWREADY  output  1: write address handshake.
REQ-010 WDATA  input  32; WVALID  input  1; WLAST  input  1; WREADY  output  1: write data handshake.
REQ-011 The block SHALL NOT have a B channel; write completion is implied by the W handshake.

Function
REQ-012 A transfer SHALL occur on any channel only on a rising edge where both VALID and READY are high.
REQ-013 The state machine SHALL have states S_IDLE, S_R_WAIT, S_R and S_W.
REQ-014 ARREADY SHALL be high only in S_IDLE with AWVALID low, giving writes priority when AWVALID and ARVALID are high together.
REQ-015 AWREADY SHALL be high only in S_IDLE; WREADY SHALL be high only in S_W.
REQ-016 The word index SHALL be ADDR[ADDR_WORDS_LOG2+1:2]; higher bits and bits [1:0] SHALL be ignored, so out-of-range addresses wrap modulo the depth.
REQ-017 On an AR handshake, the block SHALL latch the word index, load the latency counter with READ_LATENCY-1 and enter S_R_WAIT.
REQ-018 In S_R_WAIT, the counter SHALL decrement each cycle; at 0 the block SHALL load RDATA with mem[index], set RVALID and enter S_R.
REQ-019 For any READ_LATENCY, RVALID SHALL first be high exactly READ_LATENCY cycles after the AR handshake edge.
REQ-020 In S_R, RVALID and RDATA SHALL hold stable until RREADY; on the R handshake, RVALID SHALL drop next cycle and the block SHALL return to S_IDLE.
REQ-021 On an AW handshake, the block SHALL latch the word index and enter S_W.
REQ-022 On a W handshake, the block SHALL write mem[index] <= WDATA and return to S_IDLE.
REQ-023 WLAST SHALL be ignored for data; a beat with WLAST=0 SHALL still be written and terminate the burst (single-beat only).
REQ-024 A read issued after a completed write to the same index SHALL return the new data.
REQ-025 Only one transaction SHALL be outstanding; AR and AW SHALL not be accepted outside S_IDLE.
REQ-026 Minimum occupancy SHALL be READ_LATENCY+1 cycles per read and 2 cycles per write (AW handshake, then W handshake).

Reset
REQ-027 While RST is high, STATE SHALL be S_IDLE and ARREADY, AWREADY, WREADY, RVALID SHALL be 0.
REQ-028 On RST, RDATA and the latency counter SHALL be cleared to 0.
REQ-029 Reset mid-transaction SHALL abort the transaction without writing memory and without issuing RVALID.
REQ-030 RAM contents SHALL NOT be cleared by reset.

Structure
REQ-031 State encodings S_IDLE=2'b00, S_R_WAIT=2'b01, S_R=2'b10 and S_W=2'b11 SHALL live in the shared include alongside the other memory-interface constants.
REQ-032 Storage SHALL be a sub-module axi_ram_array: a single-port synchronous RAM with 1-cycle read, 2**ADDR_WORDS_LOG2 x 32, with ports addr, we, wdata and rdata.
REQ-033 The FSM, latency counter and address latches SHALL stay in axi_ram_responder.

Verification
REQ-034 Write then read: AW 0x0000_0010, W 0xDEAD_BEEF; then AR 0x10 with RREADY=1 -> RDATA=0xDEAD_BEEF, RVALID high exactly 2 cycles after the AR handshake.
REQ-035 Backpressure: read with RREADY low for 5 cycles -> RVALID and RDATA stable all 5 cycles; one transfer only.
REQ-036 Simultaneous AWVALID+ARVALID at the same index 0x20, WDATA 0x1234_5678 -> AW accepted first; the read returns 0x1234_5678.
REQ-037 Wrap: write 0xA5A5_A5A5 to 0x0000_1004 with depth 1024 -> a read of 0x0000_0004 returns 0xA5A5_A5A5.
REQ-038 Reset during S_R_WAIT and during S_W -> no RVALID, the target word is unchanged, and ARREADY/AWREADY return 1 cycle after RST falls.
